// File: rtl/spi_disp_pkg.sv
// Shared definitions for the SPI display receiver: ST7789-style command
// codes and the parser state enumeration.
package spi_disp_pkg;

  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_RASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC = 8'h3C;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CASET = 3'd1,
    S_RASET = 3'd2,
    S_RAMWR = 3'd3,
    S_SKIP  = 3'd4
  } state_e;

endpackage

// File: rtl/spi_disp_byte_rx.sv
// SPI mode-0 byte receiver, oversampled in the clk_i domain.
// Ports:
//   clk_i, rst_i           system clock, synchronous active-high reset
//   sck_i, cs_i, mosi_i,   raw SPI pins (CS active low)
//   dc_i                   D/C pin, 0 = command (used only when USE_DC=1)
//   byte_valid_o           one-cycle strobe, byte_o/is_cmd_o valid with it
//   cs_rise_o              one-cycle pulse when CS deasserts
//   partial_o              with cs_rise_o: bits of an unfinished byte remain
module spi_disp_byte_rx #(
  parameter bit USE_DC = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck_i,
  input  logic       cs_i,
  input  logic       mosi_i,
  input  logic       dc_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       is_cmd_o,
  output logic       cs_rise_o,
  output logic       partial_o
);

  // [0] first sync FF, [1] synchronised, [2] one-cycle delayed copy
  logic [2:0] sck_q, cs_q, mosi_q, dc_q;
  logic [6:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d, cnt_edge_s;
  logic       first_q, first_d, first_edge_s;
  logic       byte_valid_d, is_cmd_d, cs_rise_d, partial_d;
  logic [7:0] byte_d;
  logic       sck_rise_s, cs_rise_s;

  assign sck_rise_s = sck_q[1] & ~sck_q[2];
  assign cs_rise_s  = cs_q[1] & ~cs_q[2];

  // Shift/count on SCK rise; a byte finishing on the CS-rise cycle still counts
  // because shifting is gated by the delayed CS, while the reset of the bit
  // counter uses the synchronised CS.
  always_comb begin
    shift_d      = shift_q;
    cnt_edge_s   = cnt_q;
    first_edge_s = first_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_o;
    is_cmd_d     = is_cmd_o;
    if (sck_rise_s && !cs_q[2]) begin
      shift_d = {shift_q[5:0], mosi_q[2]};
      if (cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_d       = {shift_q, mosi_q[2]};
        is_cmd_d     = USE_DC ? ~dc_q[2] : first_q;
        first_edge_s = 1'b0;
        cnt_edge_s   = 3'd0;
      end else begin
        cnt_edge_s   = cnt_q + 3'd1;
      end
    end else begin
      shift_d = shift_q;
    end
    partial_d = cs_rise_s && (cnt_edge_s != 3'd0);
    cs_rise_d = cs_rise_s;
    cnt_d     = cs_q[1] ? 3'd0 : cnt_edge_s;
    first_d   = cs_q[1] ? 1'b1 : first_edge_s;
  end

  // Synchronisers and receiver state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q        <= 3'b000;
      cs_q         <= 3'b111;
      mosi_q       <= 3'b000;
      dc_q         <= 3'b000;
      shift_q      <= 7'd0;
      cnt_q        <= 3'd0;
      first_q      <= 1'b1;
      byte_valid_o <= 1'b0;
      byte_o       <= 8'd0;
      is_cmd_o     <= 1'b0;
      cs_rise_o    <= 1'b0;
      partial_o    <= 1'b0;
    end else begin
      sck_q        <= {sck_q[1:0], sck_i};
      cs_q         <= {cs_q[1:0], cs_i};
      mosi_q       <= {mosi_q[1:0], mosi_i};
      dc_q         <= {dc_q[1:0], dc_i};
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      first_q      <= first_d;
      byte_valid_o <= byte_valid_d;
      byte_o       <= byte_d;
      is_cmd_o     <= is_cmd_d;
      cs_rise_o    <= cs_rise_d;
      partial_o    <= partial_d;
    end
  end

endmodule

// File: rtl/spi_disp_rx.sv
// ST7789-style SPI display receiver: decodes CASET/RASET/RAMWR/RAMWRC,
// tracks the address window and emits pixels with X/Y coordinates.
// Ports:
//   i_clk, i_rst                    system clock, synchronous active-high reset
//   i_spi_clk/cs/mosi/dc            SPI pins (mode 0, CS active low)
//   o_pixel_data, o_pixel_x/_y      pixel (first byte in MSBs) and position,
//                                   held until the next o_pixel_en_pls
//   o_vsync_pls                     RAMWR decoded
//   o_abort_pls                     CS rose with a partial byte/pixel pending
module spi_disp_rx #(
  parameter bit USE_DC    = 1'b1,
  parameter int PIX_BYTES = 2,
  parameter int H_RES     = 480,
  parameter int V_RES     = 272,
  parameter int XW        = 9,
  parameter int YW        = 9
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_spi_clk,
  input  logic                   i_spi_cs,
  input  logic                   i_spi_mosi,
  input  logic                   i_spi_dc,
  output logic [8*PIX_BYTES-1:0] o_pixel_data,
  output logic [XW-1:0]          o_pixel_x,
  output logic [YW-1:0]          o_pixel_y,
  output logic                   o_pixel_en_pls,
  output logic                   o_vsync_pls,
  output logic                   o_abort_pls
);
  import spi_disp_pkg::*;

  localparam int             PW       = 8 * PIX_BYTES;
  localparam logic [15:0]    X_MAX16  = 16'(H_RES - 1);
  localparam logic [15:0]    Y_MAX16  = 16'(V_RES - 1);
  localparam logic [XW-1:0]  X_MAX    = XW'(H_RES - 1);
  localparam logic [YW-1:0]  Y_MAX    = YW'(V_RES - 1);
  localparam logic [1:0]     PIX_LAST = 2'(PIX_BYTES - 1);

  logic       rx_valid_s, rx_cmd_s, rx_cs_rise_s, rx_partial_s;
  logic [7:0] rx_byte_s;

  spi_disp_byte_rx #(.USE_DC(USE_DC)) u_byte_rx (
    .clk_i        (i_clk),
    .rst_i        (i_rst),
    .sck_i        (i_spi_clk),
    .cs_i         (i_spi_cs),
    .mosi_i       (i_spi_mosi),
    .dc_i         (i_spi_dc),
    .byte_valid_o (rx_valid_s),
    .byte_o       (rx_byte_s),
    .is_cmd_o     (rx_cmd_s),
    .cs_rise_o    (rx_cs_rise_s),
    .partial_o    (rx_partial_s)
  );

  state_e        state_q;
  logic [XW-1:0] xs_q, xe_q, x_q, xs_c_s, xe_c_s, xe_fix_s, x_adv_s;
  logic [YW-1:0] ys_q, ye_q, y_q, ys_c_s, ye_c_s, ye_fix_s, y_adv_s;
  logic [1:0]    par_cnt_q, pix_cnt_q;
  logic [23:0]   par_q;
  logic [PW-9:0] pix_buf_q;
  logic [PW-1:0] pix_word_s;
  logic [15:0]   start_raw_s, end_raw_s;
  logic          pix_pend_s, abort_s;

  // Window clamp/inversion fix, coordinate advance and abort detection
  always_comb begin
    start_raw_s = par_q[23:8];
    end_raw_s   = {par_q[7:0], rx_byte_s};
    xs_c_s   = (start_raw_s > X_MAX16) ? X_MAX : start_raw_s[XW-1:0];
    xe_c_s   = (end_raw_s > X_MAX16)   ? X_MAX : end_raw_s[XW-1:0];
    ys_c_s   = (start_raw_s > Y_MAX16) ? Y_MAX : start_raw_s[YW-1:0];
    ye_c_s   = (end_raw_s > Y_MAX16)   ? Y_MAX : end_raw_s[YW-1:0];
    xe_fix_s = (xe_c_s < xs_c_s) ? xs_c_s : xe_c_s;
    ye_fix_s = (ye_c_s < ys_c_s) ? ys_c_s : ye_c_s;
    pix_word_s = {pix_buf_q, rx_byte_s};
    if (x_q == xe_q) begin
      x_adv_s = xs_q;
      y_adv_s = (y_q == ye_q) ? ys_q : y_q + 1'b1;
    end else begin
      x_adv_s = x_q + 1'b1;
      y_adv_s = y_q;
    end
    // Pixel bytes still held after this cycle's byte (if any) is consumed
    if (rx_valid_s && rx_cmd_s) begin
      pix_pend_s = 1'b0;
    end else if (rx_valid_s && (state_q == S_RAMWR)) begin
      pix_pend_s = (pix_cnt_q != PIX_LAST);
    end else begin
      pix_pend_s = (pix_cnt_q != 2'd0);
    end
    abort_s = rx_cs_rise_s && (rx_partial_s || pix_pend_s);
  end

  // Parser FSM, window registers, address counters and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      xs_q           <= '0;
      xe_q           <= X_MAX;
      ys_q           <= '0;
      ye_q           <= Y_MAX;
      x_q            <= '0;
      y_q            <= '0;
      par_cnt_q      <= 2'd0;
      par_q          <= 24'd0;
      pix_cnt_q      <= 2'd0;
      pix_buf_q      <= '0;
      o_pixel_data   <= '0;
      o_pixel_x      <= '0;
      o_pixel_y      <= '0;
      o_pixel_en_pls <= 1'b0;
      o_vsync_pls    <= 1'b0;
      o_abort_pls    <= 1'b0;
    end else begin
      o_pixel_en_pls <= 1'b0;
      o_vsync_pls    <= 1'b0;
      o_abort_pls    <= abort_s;
      if (rx_valid_s && rx_cmd_s) begin
        par_cnt_q <= 2'd0;
        pix_cnt_q <= 2'd0;
        case (rx_byte_s)
          CMD_CASET:  state_q <= S_CASET;
          CMD_RASET:  state_q <= S_RASET;
          CMD_RAMWR: begin
            state_q     <= S_RAMWR;
            o_vsync_pls <= 1'b1;
            x_q         <= xs_q;
            y_q         <= ys_q;
          end
          CMD_RAMWRC: state_q <= S_RAMWR;
          default:    state_q <= S_SKIP;
        endcase
      end else if (rx_valid_s) begin
        case (state_q)
          S_CASET, S_RASET: begin
            if (par_cnt_q == 2'd3) begin
              if (state_q == S_CASET) begin
                xs_q <= xs_c_s;
                xe_q <= xe_fix_s;
              end else begin
                ys_q <= ys_c_s;
                ye_q <= ye_fix_s;
              end
              par_cnt_q <= 2'd0;
              state_q   <= S_IDLE;
            end else begin
              par_q     <= {par_q[15:0], rx_byte_s};
              par_cnt_q <= par_cnt_q + 2'd1;
            end
          end
          S_RAMWR: begin
            pix_buf_q <= pix_word_s[PW-9:0];
            if (pix_cnt_q == PIX_LAST) begin
              pix_cnt_q      <= 2'd0;
              o_pixel_en_pls <= 1'b1;
              o_pixel_data   <= pix_word_s;
              o_pixel_x      <= x_q;
              o_pixel_y      <= y_q;
              x_q            <= x_adv_s;
              y_q            <= y_adv_s;
            end else begin
              pix_cnt_q <= pix_cnt_q + 2'd1;
            end
          end
          default: ;
        endcase
      end
      // Applied after the byte path so a byte completing with CS rise is kept
      if (rx_cs_rise_s) begin
        pix_cnt_q <= 2'd0;
        if (!USE_DC) begin
          state_q   <= S_IDLE;
          par_cnt_q <= 2'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_disp_rx.sv
// Scoreboard bench for spi_disp_rx: dut_a (4-wire, RGB565) and
// dut_b (no D/C, 3-byte pixels). A byte-level reference model pushes
// expected events; a negedge monitor pops and compares DUT pulses.
module tb_spi_disp_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sck[2], cs[2], mosi[2], dc[2];
  logic [15:0] a_data; logic [8:0] a_x, a_y; logic a_pe, a_vs, a_ab;
  logic [23:0] b_data; logic [8:0] b_x, b_y; logic b_pe, b_vs, b_ab;

  spi_disp_rx #(.USE_DC(1'b1), .PIX_BYTES(2)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_spi_clk(sck[0]), .i_spi_cs(cs[0]),
    .i_spi_mosi(mosi[0]), .i_spi_dc(dc[0]), .o_pixel_data(a_data),
    .o_pixel_x(a_x), .o_pixel_y(a_y), .o_pixel_en_pls(a_pe),
    .o_vsync_pls(a_vs), .o_abort_pls(a_ab));

  spi_disp_rx #(.USE_DC(1'b0), .PIX_BYTES(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_spi_clk(sck[1]), .i_spi_cs(cs[1]),
    .i_spi_mosi(mosi[1]), .i_spi_dc(dc[1]), .o_pixel_data(b_data),
    .o_pixel_x(b_x), .o_pixel_y(b_y), .o_pixel_en_pls(b_pe),
    .o_vsync_pls(b_vs), .o_abort_pls(b_ab));

  typedef struct { int kind; int data; int x; int y; } ev_t; // 0 vsync, 1 pixel, 2 abort
  ev_t qa[$], qb[$];
  int checks = 0, failures = 0;

  localparam int M_IDLE = 0, M_CAS = 1, M_RAS = 2, M_RAM = 3, M_SKIP = 4;
  int m_mode[2], m_xs[2], m_xe[2], m_ys[2], m_ye[2], m_x[2], m_y[2];
  int m_par[2][4], m_npar[2], m_pix[2], m_npix[2], m_frame[2];

  function automatic void push_ev(int k, int kind, int data, int x, int y);
    ev_t e;
    e.kind = kind; e.data = data; e.x = x; e.y = y;
    if (k == 0) qa.push_back(e); else qb.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_xs[k] = 0; m_xe[k] = 479; m_ys[k] = 0; m_ye[k] = 271;
      m_x[k] = 0; m_y[k] = 0; m_npar[k] = 0; m_pix[k] = 0; m_npix[k] = 0; m_frame[k] = 0;
    end
    qa.delete(); qb.delete();
  endfunction

  function automatic void model_byte(int k, int b, bit is_cmd);
    int pb = (k == 0) ? 2 : 3;
    int s, e, mx;
    if (is_cmd) begin
      m_npar[k] = 0; m_npix[k] = 0; m_pix[k] = 0;
      case (b)
        8'h2A: m_mode[k] = M_CAS;
        8'h2B: m_mode[k] = M_RAS;
        8'h2C: begin push_ev(k, 0, 0, 0, 0); m_x[k] = m_xs[k]; m_y[k] = m_ys[k]; m_mode[k] = M_RAM; end
        8'h3C: m_mode[k] = M_RAM;
        default: m_mode[k] = M_SKIP;
      endcase
    end else if (m_mode[k] == M_CAS || m_mode[k] == M_RAS) begin
      m_par[k][m_npar[k]] = b;
      m_npar[k]++;
      if (m_npar[k] == 4) begin
        mx = (m_mode[k] == M_CAS) ? 479 : 271;
        s = m_par[k][0] * 256 + m_par[k][1];
        e = m_par[k][2] * 256 + m_par[k][3];
        if (s > mx) s = mx;
        if (e > mx) e = mx;
        if (e < s) e = s;
        if (m_mode[k] == M_CAS) begin m_xs[k] = s; m_xe[k] = e; end
        else begin m_ys[k] = s; m_ye[k] = e; end
        m_npar[k] = 0; m_mode[k] = M_IDLE;
      end
    end else if (m_mode[k] == M_RAM) begin
      m_pix[k] = m_pix[k] * 256 + b;
      m_npix[k]++;
      if (m_npix[k] == pb) begin
        push_ev(k, 1, m_pix[k], m_x[k], m_y[k]);
        if (m_x[k] == m_xe[k]) begin
          m_x[k] = m_xs[k];
          m_y[k] = (m_y[k] == m_ye[k]) ? m_ys[k] : (m_y[k] + 1) % 512;
        end else begin
          m_x[k] = (m_x[k] + 1) % 512;
        end
        m_npix[k] = 0; m_pix[k] = 0;
      end
    end
  endfunction

  function automatic void model_cs_rise(int k, int bits);
    if (bits != 0 || m_npix[k] != 0) push_ev(k, 2, 0, 0, 0);
    m_npix[k] = 0; m_pix[k] = 0;
    if (k == 1) begin m_mode[k] = M_IDLE; m_npar[k] = 0; end
  endfunction

  function automatic void check_ev(int k, int kind, int data, int x, int y);
    ev_t e;
    checks++;
    if ((k == 0 && qa.size() == 0) || (k == 1 && qb.size() == 0)) begin
      failures++;
      $display("FAIL dut%0d unexpected_event got kind=%0d data=%h (%0d,%0d) required no event", k, kind, data, x, y);
      return;
    end
    if (k == 0) e = qa.pop_front(); else e = qb.pop_front();
    if (e.kind != kind || (kind == 1 && (e.data != data || e.x != x || e.y != y))) begin
      failures++;
      $display("FAIL dut%0d event got kind=%0d data=%h (%0d,%0d) required kind=%0d data=%h (%0d,%0d)",
               k, kind, data, x, y, e.kind, e.data, e.x, e.y);
    end
  endfunction

  // Monitor: every DUT pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (a_vs) check_ev(0, 0, 0, 0, 0);
      if (a_pe) check_ev(0, 1, int'(a_data), int'(a_x), int'(a_y));
      if (a_ab) check_ev(0, 2, 0, 0, 0);
      if (b_vs) check_ev(1, 0, 0, 0, 0);
      if (b_pe) check_ev(1, 1, int'(b_data), int'(b_x), int'(b_y));
      if (b_ab) check_ev(1, 2, 0, 0, 0);
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic shift_bits(input int k, input logic [7:0] b, input int n, input logic dcv);
    for (int i = 0; i < n; i++) begin
      mosi[k] = b[7-i]; dc[k] = dcv;
      clk_wait(4); sck[k] = 1'b1;
      clk_wait(4); sck[k] = 1'b0;
    end
  endtask

  task automatic send(input int k, input int b, input bit cmd);
    bit is_cmd = (k == 0) ? cmd : (m_frame[k] == 0);
    model_byte(k, b, is_cmd);
    m_frame[k]++;
    shift_bits(k, 8'(b), 8, ~cmd);
  endtask

  task automatic cs_low(input int k);
    cs[k] = 1'b0; m_frame[k] = 0; clk_wait(4);
  endtask

  task automatic cs_high(input int k, input int bits);
    model_cs_rise(k, bits);
    clk_wait(2); cs[k] = 1'b1; clk_wait(8);
  endtask

  task automatic check_zero();
    checks++;
    if ({a_data, a_x, a_y, a_pe, a_vs, a_ab, b_data, b_x, b_y, b_pe, b_vs, b_ab} != '0) begin
      failures++;
      $display("FAIL reset_outputs got a=%h,%0d,%0d b=%h,%0d,%0d required all zero", a_data, a_x, a_y, b_data, b_x, b_y);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; clk_wait(3); model_reset();
    @(negedge clk); check_zero();
    rst = 1'b0; clk_wait(2);
  endtask

  task automatic rand_frame(input int k);
    int r = $urandom_range(0, 5);
    int cmd = (r == 0) ? 8'h2A : (r == 1) ? 8'h2B : (r == 2) ? 8'h2C : (r == 3) ? 8'h3C : $urandom_range(0, 255);
    int n = (cmd == 8'h2A || cmd == 8'h2B) ? $urandom_range(2, 5) : $urandom_range(0, 9);
    int tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
    cs_low(k);
    send(k, cmd, 1'b1);
    for (int i = 0; i < n; i++)
      send(k, (i % 2 == 0 && (cmd == 8'h2A || cmd == 8'h2B)) ? $urandom_range(0, 2) : $urandom_range(0, 255), 1'b0);
    if (tail != 0) shift_bits(k, 8'($urandom_range(0, 255)), tail, 1'b1);
    cs_high(k, tail);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin sck[k] = 1'b0; cs[k] = 1'b1; mosi[k] = 1'b0; dc[k] = 1'b1; end
    do_reset();
    // Basic RAMWR
    cs_low(0);
    send(0, 8'h2C, 1'b1);
    send(0, 8'hF8, 1'b0); send(0, 8'h00, 1'b0); send(0, 8'h07, 1'b0); send(0, 8'hE0, 1'b0);
    // Window wrap
    send(0, 8'h2A, 1'b1); send(0, 0, 1'b0); send(0, 10, 1'b0); send(0, 0, 1'b0); send(0, 11, 1'b0);
    send(0, 8'h2B, 1'b1); send(0, 0, 1'b0); send(0, 5, 1'b0); send(0, 0, 1'b0); send(0, 6, 1'b0);
    send(0, 8'h2C, 1'b1);
    for (int i = 0; i < 10; i++) send(0, 8'h10 + i, 1'b0);
    // Clamp (end 1023 -> 479) then inversion (end 10 < start 20)
    send(0, 8'h2A, 1'b1); send(0, 1, 1'b0); send(0, 8'hDE, 1'b0); send(0, 8'h03, 1'b0); send(0, 8'hFF, 1'b0);
    send(0, 8'h2C, 1'b1);
    for (int i = 0; i < 6; i++) send(0, 8'hA0 + i, 1'b0);
    send(0, 8'h2A, 1'b1); send(0, 0, 1'b0); send(0, 20, 1'b0); send(0, 0, 1'b0); send(0, 10, 1'b0);
    send(0, 8'h2C, 1'b1);
    for (int i = 0; i < 4; i++) send(0, 8'h55 + i, 1'b0);
    // Interrupted CASET is discarded
    send(0, 8'h2A, 1'b1); send(0, 0, 1'b0); send(0, 3, 1'b0);
    send(0, 8'h2C, 1'b1); send(0, 8'h12, 1'b0); send(0, 8'h34, 1'b0);
    // Abort after 11 bits, then resume across CS frames
    send(0, 8'hC3, 1'b0); shift_bits(0, 8'hFF, 3, 1'b1);
    cs_high(0, 3);
    cs_low(0); send(0, 8'h9A, 1'b0); send(0, 8'hBC, 1'b0);
    send(0, 8'h77, 1'b0); cs_high(0, 0);          // whole byte, partial pixel
    cs_low(0); send(0, 8'h01, 1'b0); send(0, 8'h02, 1'b0); cs_high(0, 0);
    // No D/C pin, 3-byte pixels
    cs_low(1); send(1, 8'h2C, 1'b0); send(1, 8'h12, 1'b0); send(1, 8'h34, 1'b0); send(1, 8'h56, 1'b0); cs_high(1, 0);
    cs_low(1); send(1, 8'h00, 1'b0); send(1, 8'h11, 1'b0); send(1, 8'h22, 1'b0); send(1, 8'h33, 1'b0); cs_high(1, 0);
    cs_low(1); send(1, 8'h3C, 1'b0); send(1, 8'hAB, 1'b0); send(1, 8'hCD, 1'b0); send(1, 8'hEF, 1'b0); cs_high(1, 0);
    // Reset mid-stream
    cs_low(0); send(0, 8'h2C, 1'b1); send(0, 8'h44, 1'b0); send(0, 8'h55, 1'b0); send(0, 8'h66, 1'b0);
    clk_wait(10);
    do_reset();
    for (int i = 0; i < 4; i++) send(0, 8'h80 + i, 1'b0);
    send(0, 8'h2C, 1'b1); send(0, 8'hDE, 1'b0); send(0, 8'hAD, 1'b0);
    cs_high(0, 0);
    // Randomised frames on both receivers
    for (int i = 0; i < 30; i++) rand_frame($urandom_range(0, 1));
    // Drain and confirm nothing expected is outstanding
    for (int i = 0; i < 300 && (qa.size() != 0 || qb.size() != 0); i++) @(posedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      failures++;
      $display("FAIL drain got pending a=%0d b=%0d required 0 0", qa.size(), qb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
